borrow_lookahead_sub_pipe: RTL and testbench
============================================

# borrow_lookahead_sub_pipe

Pipelined WIDTH-bit subtractor computing D = A − B − B_in. Each pipeline stage resolves one GROUP-bit slice with a borrow-lookahead network, which is the subtraction counterpart of the team's 4-bit carry-lookahead adder. It sits in the arithmetic datapath beside the adders and accepts one operand pair per cycle under a valid/ready handshake. Its group structure matches the adder so that delay comparisons between the two blocks stay like-for-like.

## Interface
- WIDTH, 16, operand and result width; must be a multiple of GROUP.
- GROUP, 4, bits resolved per pipeline stage; number of stages N = WIDTH/GROUP.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block can accept a beat this cycle.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- B_in  input  1  borrow-in.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- D  output  WIDTH  difference.
- B_out  output  1  borrow-out from the MSB.
- V  output  1  signed (two's-complement) overflow.
- Z  output  1  D == 0.

## Operation
- Per bit i: g_i = ~A_i & B_i; p_i = ~(A_i ^ B_i); borrow_{i+1} = g_i | (p_i & borrow_i); D_i = A_i ^ B_i ^ borrow_i.
- Within a group, borrows are computed in flattened lookahead (sum-of-products) form, not ripple.
- Stage k (k = 0..N−1) computes group k from the borrow registered by stage k−1. Stage 0 uses B_in.
- Unprocessed high operand groups are carried forward in stage registers. Finished low D groups are carried forward as well.
- Single global advance: adv = ~out_valid | out_ready. All stage registers, including their valid bits, load only when adv = 1.
- in_ready = adv & ~rst. A beat is accepted when in_valid & in_ready.
- Bubbles propagate as invalid stages. Invalid stages keep flowing when adv = 1; there is no bubble collapsing.
- B_out = borrow out of bit WIDTH−1. With B_in = 0, B_out = 1 exactly when A < B unsigned.
- V = (A_msb ^ B_msb) & (D_msb ^ A_msb), taken from the beat's own operands.
- Outputs are registered. D, B_out, V and Z are meaningful only while out_valid = 1, and hold stable while out_valid & ~out_ready.

## Timing
- Reset: on any edge with rst = 1, all valid bits clear and out_valid, D, B_out, V and Z all become 0. in_ready is 0 while rst = 1 and 1 on the first cycle after release.
- Reset mid-operation discards every in-flight beat; no partial result is ever presented.
- Latency: a beat accepted at edge t is presented with out_valid = 1 after edge t+N−1, provided no stall occurs. For N = 4 that is 3 edges after acceptance, visible in the 4th cycle.
- Throughput is one beat per cycle while out_ready = 1.
- Stall: out_valid & ~out_ready freezes the whole pipeline. in_ready drops in the same cycle, combinationally from out_ready, and no accepted beat is lost or duplicated.
- Simultaneous events: when out_valid & out_ready & in_valid & in_ready hold on the same edge, the output beat retires and a new beat enters.
- Wrap-around: differences are modulo 2^WIDTH. For example, 0x0000 − 0x0001 gives D = 0xFFFF with B_out = 1.

## Configuration
- SUB_FLAGS_EN defined: V and Z are computed and pipelined with the beat, as specified above.
- SUB_FLAGS_EN undefined: the flag logic and its pipeline bits are removed, and V and Z are tied to 0. D, B_out, the handshake and latency are unchanged.

## Test plan
- Basic subtraction: reset, then A = 0x0005, B = 0x0003, B_in = 0 → after latency D = 0x0002, B_out = 0, V = 0, Z = 0.
- Wrap-around and zero result:
  - A = 0x0000, B = 0x0001, B_in = 0 → D = 0xFFFF, B_out = 1.
  - A = 0x1234, B = 0x1233, B_in = 1 → D = 0x0000, Z = 1, B_out = 0.
- Borrow across all group boundaries and signed overflow:
  - A = 0x1000, B = 0x0001 → D = 0x0FFF, B_out = 0.
  - A = 0x8000, B = 0x0001 → D = 0x7FFF, V = 1 (V = 0 when SUB_FLAGS_EN is undefined).
- Streaming with backpressure:
  - Stimulus: 8 back-to-back beats A = k·0x1111, B = 0x0101. Hold out_ready = 0 for 3 cycles mid-stream.
  - Required: all 8 results appear in order, each D = k·0x1111 − 0x0101; in_ready = 0 exactly during the stall; outputs stay stable while stalled.
- Reset mid-operation: accept 3 beats, then assert rst for 1 cycle → out_valid stays 0 until new beats are accepted; the first new result appears exactly N−1 edges after its acceptance.

Source files
------------

// File: rtl/borrow_lookahead_sub_pipe.sv
// Pipelined WIDTH-bit subtractor D = A - B - B_in, one GROUP-bit borrow-lookahead slice per stage.
// Define SUB_FLAGS_EN to compute and pipeline the V (signed overflow) and Z (zero) flags.
module borrow_lookahead_sub_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             B_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             B_out,
  output logic             V,
  output logic             Z
);

  localparam int unsigned N = WIDTH / GROUP;

  // Group subtract: flattened sum-of-products borrows, returns {borrow_out, diff}
  function automatic logic [GROUP:0] grp_sub(input logic [GROUP-1:0] a,
                                             input logic [GROUP-1:0] b,
                                             input logic             bin);
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   bw;
    logic             term;
    g = ~a & b;
    p = ~(a ^ b);
    for (int unsigned j = 0; j <= GROUP; j++) begin
      term = bin;
      for (int unsigned m = 0; m < j; m++) term = term & p[m];
      bw[j] = term;
      for (int unsigned m = 0; m < j; m++) begin
        term = g[m];
        for (int unsigned q = m + 1; q < j; q++) term = term & p[q];
        bw[j] = bw[j] | term;
      end
    end
    return {bw[GROUP], a ^ b ^ bw[GROUP-1:0]};
  endfunction

  logic [N-1:0]     vld_q;
  logic [N-1:0]     brw_q;
  logic [WIDTH-1:0] a_q [N];
  logic [WIDTH-1:0] b_q [N];
  logic [WIDTH-1:0] d_q [N];

  logic [N-1:0]     cur_vld;
  logic [N-1:0]     cur_bin;
  logic [WIDTH-1:0] cur_a [N];
  logic [WIDTH-1:0] cur_b [N];
  logic [WIDTH-1:0] nxt_d [N];
  logic [GROUP:0]   grp   [N];
  logic             adv;

  assign adv      = ~vld_q[N-1] | out_ready;
  assign in_ready = adv & ~rst;

  // Stage k resolves group k from the beat held in rank k-1 (inputs for stage 0)
  always_comb begin
    cur_vld[0] = in_valid & in_ready;
    cur_bin[0] = B_in;
    cur_a[0]   = A;
    cur_b[0]   = B;
    nxt_d[0]   = '0;
    for (int unsigned k = 1; k < N; k++) begin
      cur_vld[k] = vld_q[k-1];
      cur_bin[k] = brw_q[k-1];
      cur_a[k]   = a_q[k-1];
      cur_b[k]   = b_q[k-1];
      nxt_d[k]   = d_q[k-1];
    end
    for (int unsigned k = 0; k < N; k++) begin
      grp[k] = grp_sub(cur_a[k][k*GROUP +: GROUP], cur_b[k][k*GROUP +: GROUP], cur_bin[k]);
      nxt_d[k][k*GROUP +: GROUP] = grp[k][GROUP-1:0];
    end
  end

  // One global advance moves every rank, bubbles included
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      brw_q <= '0;
      for (int unsigned k = 0; k < N; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        d_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q <= cur_vld;
      for (int unsigned k = 0; k < N; k++) begin
        brw_q[k] <= grp[k][GROUP];
        a_q[k]   <= cur_a[k];
        b_q[k]   <= cur_b[k];
        d_q[k]   <= nxt_d[k];
      end
    end
  end

  assign out_valid = vld_q[N-1];
  assign D         = d_q[N-1];
  assign B_out     = brw_q[N-1];

`ifdef SUB_FLAGS_EN
  logic v_q;
  logic z_q;

  // Flags are formed as the last group completes, so they travel with the beat
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
      z_q <= 1'b0;
    end else if (adv) begin
      v_q <= (cur_a[N-1][WIDTH-1] ^ cur_b[N-1][WIDTH-1]) &
             (nxt_d[N-1][WIDTH-1] ^ cur_a[N-1][WIDTH-1]);
      z_q <= (nxt_d[N-1] == '0);
    end
  end

  assign V = v_q;
  assign Z = z_q;
`else
  assign V = 1'b0;
  assign Z = 1'b0;
`endif

endmodule

// File: tb/tb_borrow_lookahead_sub_pipe.sv
// Randomized and directed bench for borrow_lookahead_sub_pipe against an arithmetic reference model.
module tb_borrow_lookahead_sub_pipe;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned GROUP = 4;
  localparam int unsigned N     = WIDTH / GROUP;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             v;
    logic             z;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             B_in = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] D;
  logic             B_out;
  logic             V;
  logic             Z;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  borrow_lookahead_sub_pipe #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .B_in(B_in), .out_valid(out_valid), .out_ready(out_ready),
    .D(D), .B_out(B_out), .V(V), .Z(Z)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference: plain wide arithmetic for the difference, signed integer range for overflow
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
    exp_t       e;
    logic [WIDTH:0] r;
    int         s;
    r    = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(bin);
    e.d  = r[WIDTH-1:0];
    e.bo = r[WIDTH];
    s    = int'($signed(a)) - int'($signed(b)) - int'(bin);
`ifdef SUB_FLAGS_EN
    e.v  = (s > 32767) || (s < -32768);
    e.z  = (e.d == '0);
`else
    e.v  = 1'b0;
    e.z  = 1'b0;
`endif
    return e;
  endfunction

  // Scoreboard: compare the head of the expected queue whenever a result is presented
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check("in_ready_in_reset", 32'(in_ready), 32'd0);
      exp_q.delete();
    end else begin
      check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q[0];
          check("D", 32'(D), 32'(e.d));
          check("B_out", 32'(B_out), 32'(e.bo));
          check("V", 32'(V), 32'(e.v));
          check("Z", 32'(Z), 32'(e.z));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(A, B, B_in));
    end
  end

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
    logic fired;
    int   tries;
    in_valid = 1'b1; A = a; B = b; B_in = bin;
    fired = 1'b0; tries = 0;
    while (!fired && tries < 100) begin
      @(negedge clk); fired = in_ready;
      @(posedge clk); #1; tries++;
    end
    if (!fired) check("send_timeout", 32'(fired), 32'd1);
    in_valid = 1'b0;
  endtask

  // Single beat into an empty pipe: out_valid must rise exactly N-1 edges after acceptance
  task automatic one_beat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
    out_ready = 1'b1;
    send(a, b, bin);
    for (int i = 0; i < int'(N) - 1; i++) begin
      @(negedge clk); check("latency_early", 32'(out_valid), 32'd0);
    end
    @(negedge clk); check("latency_due", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int i;
    in_valid = 1'b0; out_ready = 1'b1;
    i = 0;
    while (exp_q.size() > 0 && i < 100) begin
      @(posedge clk); #1; i++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic fired;
    int   k, cyc, sent;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_D", 32'(D), 32'd0);
    check("rst_B_out", 32'(B_out), 32'd0);
    check("rst_V", 32'(V), 32'd0);
    check("rst_Z", 32'(Z), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); check("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Directed corner cases
    one_beat(16'h0005, 16'h0003, 1'b0);
    one_beat(16'h0000, 16'h0001, 1'b0);
    one_beat(16'h1234, 16'h1233, 1'b1);
    one_beat(16'h1000, 16'h0001, 1'b0);
    one_beat(16'h8000, 16'h0001, 1'b0);
    one_beat(16'hFFFF, 16'hFFFF, 1'b1);
    drain();

    // Streaming with a 3-cycle stall mid-stream
    k = 0; cyc = 0;
    while (k < 8 && cyc < 100) begin
      in_valid  = 1'b1;
      A         = 16'(k * 16'h1111);
      B         = 16'h0101;
      B_in      = 1'b0;
      out_ready = !(cyc >= 5 && cyc < 8);
      @(negedge clk); fired = in_ready;
      @(posedge clk); #1; cyc++;
      if (fired) k++;
    end
    if (k < 8) check("stream_timeout", 32'(k), 32'd8);
    drain();

    // Reset mid-operation discards in-flight beats
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(16'(16'h0100 * (i + 1)), 16'h0011, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); check("post_rst_idle", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    one_beat(16'hABCD, 16'h1234, 1'b1);
    drain();

    // Randomized traffic with random backpressure
    sent = 0; cyc = 0;
    while (sent < 300 && cyc < 5000) begin
      if (!in_valid && $urandom_range(0, 9) < 7) begin
        in_valid = 1'b1;
        case ($urandom_range(0, 4))
          0:       A = 16'h0000;
          1:       A = 16'h8000;
          default: A = 16'($urandom);
        endcase
        B    = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
        B_in = 1'($urandom);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk); fired = in_valid && in_ready;
      @(posedge clk); #1; cyc++;
      if (fired) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    if (sent < 300) check("random_timeout", 32'(sent), 32'd300);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
